// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the arbiter and the shared memory.
//   Fetch port  : i_read, i_addr -> i_rdata, i_busywait
//   Data port   : d_read, d_write, d_addr, d_wdata -> d_rdata, d_busywait
//   Memory port : m_read, m_write, m_addr, m_wdata -> memory; m_rdata, m_ready <- memory
//   Status      : error (sticky timeout flag)
// The slave modport is the arbiter's view; the master modport is the environment's
// view (requesters plus memory).
interface mem_arbiter_if;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_busywait;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_busywait;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        error;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_busywait, d_rdata, d_busywait, m_read, m_write, m_addr, m_wdata, error
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_busywait, d_rdata, d_busywait, m_read, m_write, m_addr, m_wdata, error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch stage (read-only
// port) and the memory-access stage (read/write port). Each access runs through a
// registered FSM IDLE -> ACC -> DONE -> IDLE; the requester's busywait drops only in its
// DONE cycle. A per-access watchdog ends an access that never sees m_ready and sets a
// sticky error flag.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   bus_io  : mem_arbiter_if.slave (fetch, data, memory and error signals)
// Parameter Timeout: cycles an access may wait for m_ready; 0 disables the watchdog.
module mem_arbiter #(
  parameter int unsigned Timeout = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus_io
);

  localparam int unsigned CntW = ($clog2(Timeout + 1) > 8) ? $clog2(Timeout + 1) : 8;

  typedef enum logic [2:0] {StIdle, StIAcc, StDAcc, StIDone, StDDone} state_e;

  state_e          state_q;
  logic            last_d_q;  // 1: data port was served most recently
  logic [CntW-1:0] cnt_q;
  logic [31:0]     i_rdata_q;
  logic [31:0]     d_rdata_q;
  logic [31:0]     m_addr_q;
  logic [31:0]     m_wdata_q;
  logic            m_read_q;
  logic            m_write_q;
  logic            error_q;

  logic i_req;
  logic d_req;
  logic timed_out;

  assign i_req     = bus_io.i_read;
  assign d_req     = bus_io.d_read | bus_io.d_write;
  assign timed_out = (Timeout != 0) && (cnt_q == CntW'(Timeout));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Data wins when alone, or when both request and fetch was served last.
          if (d_req && (!i_req || !last_d_q)) begin
            state_q   <= StDAcc;
            m_addr_q  <= bus_io.d_addr;
            m_write_q <= bus_io.d_write;  // read+write together is a write
            m_read_q  <= ~bus_io.d_write;
            m_wdata_q <= bus_io.d_write ? bus_io.d_wdata : '0;
            cnt_q     <= '0;
          end else if (i_req) begin
            state_q   <= StIAcc;
            m_addr_q  <= bus_io.i_addr;
            m_write_q <= 1'b0;
            m_read_q  <= 1'b1;
            m_wdata_q <= '0;
            cnt_q     <= '0;
          end
        end
        StIAcc: begin
          if (bus_io.m_ready || timed_out) begin
            i_rdata_q <= bus_io.m_ready ? bus_io.m_rdata : '0;
            if (!bus_io.m_ready) error_q <= 1'b1;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            last_d_q  <= 1'b0;
            state_q   <= StIDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDAcc: begin
          if (bus_io.m_ready || timed_out) begin
            // Writes leave d_rdata untouched, even when they time out.
            if (m_read_q) d_rdata_q <= bus_io.m_ready ? bus_io.m_rdata : '0;
            if (!bus_io.m_ready) error_q <= 1'b1;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            last_d_q  <= 1'b1;
            state_q   <= StDDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StIDone, StDDone: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

  // Combinational so the stall follows the request even while in reset.
  assign bus_io.i_busywait = i_req & (state_q != StIDone);
  assign bus_io.d_busywait = d_req & (state_q != StDDone);

  assign bus_io.i_rdata = i_rdata_q;
  assign bus_io.d_rdata = d_rdata_q;
  assign bus_io.m_read  = m_read_q;
  assign bus_io.m_write = m_write_q;
  assign bus_io.m_addr  = m_addr_q;
  assign bus_io.m_wdata = m_wdata_q;
  assign bus_io.error   = error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level schedule model.
module tb_mem_arbiter;
  localparam int unsigned Timeout = 4;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.Timeout(Timeout)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ready = 1'b0;
  endtask

  // Random-phase model: an access granted in cycle g with effective latency le strobes
  // in cycles g+1..g+1+le, finishes (DONE) in g+2+le and the arbiter is free at g+3+le.
  int          t, free_at, acc_start, acc_end, done_t, last_port, act_port, lat, le;
  bit          act, act_ready, act_wr, in_acc;
  logic [31:0] act_addr, act_wdata, act_rdata;
  bit          req[2];
  bit          finished[2];
  logic [31:0] req_addr[2];
  logic [31:0] req_wdata;
  int unsigned d_cmd;  // 0 read, 1 write, 2 read+write
  logic [31:0] exp_ir, exp_dr;
  bit          exp_err;

  initial begin
    // ---- reset, lone fetch with L=0 ----
    rst = 1'b1;
    quiet_inputs();
    step();
    bus.i_read = 1'b1;
    sample();
    check("rst_i_busywait_follows", bus.i_busywait, 1'b1);
    check("rst_m_read", bus.m_read, 1'b0);
    check("rst_m_write", bus.m_write, 1'b0);
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_m_wdata", bus.m_wdata, 32'h0);
    check("rst_i_rdata", bus.i_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    check("rst_error", bus.error, 1'b0);
    step();
    rst = 1'b0;
    bus.i_addr = 32'h0000_0010;
    sample();
    check("fetch_c0_busywait", bus.i_busywait, 1'b1);
    check("fetch_c0_m_read", bus.m_read, 1'b0);
    step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0050_0093;
    sample();
    check("fetch_c1_m_read", bus.m_read, 1'b1);
    check("fetch_c1_m_addr", bus.m_addr, 32'h0000_0010);
    step();
    bus.m_ready = 1'b0;
    sample();
    check("fetch_c2_busywait", bus.i_busywait, 1'b0);
    check("fetch_c2_rdata", bus.i_rdata, 32'h0050_0093);
    step();
    bus.i_read = 1'b0;
    sample();
    check("fetch_c3_m_read", bus.m_read, 1'b0);

    // ---- data write with L=3 ----
    step();
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF;
    sample();
    check("wr_c0_busywait", bus.d_busywait, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.m_ready = (k == 4);
      bus.m_rdata = $urandom;
      sample();
      check("wr_acc_m_write", bus.m_write, 1'b1);
      check("wr_acc_m_read", bus.m_read, 1'b0);
      check("wr_acc_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      check("wr_acc_busywait", bus.d_busywait, 1'b1);
    end
    check("wr_m_addr", bus.m_addr, 32'h0000_0100);
    step();
    bus.m_ready = 1'b0;
    sample();
    check("wr_c5_busywait", bus.d_busywait, 1'b0);
    check("wr_c5_m_write", bus.m_write, 1'b0);
    check("wr_d_rdata_untouched", bus.d_rdata, 32'h0);
    step();
    bus.d_write = 1'b0;

    // ---- contention after reset: D, then I, then D again ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_0A00;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_0D00;
    sample();
    check("cont_c0_i_bw", bus.i_busywait, 1'b1);
    check("cont_c0_d_bw", bus.d_busywait, 1'b1);
    step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h1111_2222;
    sample();
    check("cont_first_grant_d", bus.m_addr, 32'h0000_0D00);
    step();
    bus.m_ready = 1'b0;
    sample();
    check("cont_d_done_bw", bus.d_busywait, 1'b0);
    check("cont_i_still_bw", bus.i_busywait, 1'b1);
    check("cont_d_rdata", bus.d_rdata, 32'h1111_2222);
    step();
    sample();
    check("cont_idle_m_read", bus.m_read, 1'b0);
    step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h3333_4444;
    sample();
    check("cont_second_grant_i", bus.m_addr, 32'h0000_0A00);
    step();
    bus.m_ready = 1'b0;
    sample();
    check("cont_i_done_bw", bus.i_busywait, 1'b0);
    check("cont_i_rdata", bus.i_rdata, 32'h3333_4444);
    check("cont_d_waits", bus.d_busywait, 1'b1);
    step();
    step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h5555_6666;
    sample();
    check("cont_third_grant_d", bus.m_addr, 32'h0000_0D00);
    step();
    bus.m_ready = 1'b0;
    bus.i_read  = 1'b0;
    sample();
    check("cont_third_rdata", bus.d_rdata, 32'h5555_6666);
    step();
    bus.d_read = 1'b0;

    // ---- timeout with Timeout=4 ----
    step();
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_0200;
    for (int k = 1; k <= 5; k++) begin
      step();
      sample();
      check("to_acc_m_read", bus.m_read, 1'b1);
      check("to_acc_busywait", bus.d_busywait, 1'b1);
      check("to_acc_error", bus.error, 1'b0);
    end
    step();
    sample();
    check("to_done_busywait", bus.d_busywait, 1'b0);
    check("to_done_rdata_zero", bus.d_rdata, 32'h0);
    check("to_done_error", bus.error, 1'b1);
    step();
    bus.d_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      sample();
      check("to_error_sticky", bus.error, 1'b1);
    end

    // ---- asynchronous reset during a data write ----
    step();
    bus.d_write = 1'b1;
    bus.d_wdata = 32'hCAFE_F00D;
    step();
    sample();
    check("rstmid_m_write_before", bus.m_write, 1'b1);
    step();
    rst = 1'b1;
    #1;
    check("rstmid_m_write_async", bus.m_write, 1'b0);
    check("rstmid_m_wdata_async", bus.m_wdata, 32'h0);
    check("rstmid_error_cleared", bus.error, 1'b0);
    check("rstmid_d_bw_follows", bus.d_busywait, 1'b1);
    step();
    bus.d_write = 1'b0;
    step();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h7777_8888;
    sample();
    check("rstmid_stray_m_read", bus.m_read, 1'b0);
    check("rstmid_stray_m_write", bus.m_write, 1'b0);
    step();
    bus.m_ready = 1'b0;
    sample();
    check("rstmid_stray_d_rdata", bus.d_rdata, 32'h0);
    check("rstmid_stray_i_rdata", bus.i_rdata, 32'h0);

    // ---- fetch request withdrawn mid-access ----
    step();
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_0040;
    step();
    bus.i_read = 1'b0;
    sample();
    check("wd_c1_m_read", bus.m_read, 1'b1);
    check("wd_c1_i_bw", bus.i_busywait, 1'b0);
    step();
    sample();
    check("wd_c2_m_read", bus.m_read, 1'b1);
    step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h9999_AAAA;
    sample();
    check("wd_c3_m_read", bus.m_read, 1'b1);
    step();
    bus.m_ready = 1'b0;
    sample();
    check("wd_done_m_read", bus.m_read, 1'b0);
    check("wd_done_i_bw", bus.i_busywait, 1'b0);
    step();
    step();
    sample();
    check("wd_no_regrant", bus.m_read, 1'b0);

    // ---- randomized traffic against the schedule model ----
    rst = 1'b1;
    quiet_inputs();
    step();
    rst = 1'b0;
    free_at = 0;
    last_port = 0;
    act = 1'b0;
    in_acc = 1'b0;
    exp_ir = '0;
    exp_dr = '0;
    exp_err = 1'b0;
    d_cmd = 0;
    req_wdata = '0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0;
      finished[p] = 1'b0;
      req_addr[p] = '0;
    end
    for (t = 0; t < 1500; t++) begin
      if (t > 0) step();
      for (int p = 0; p < 2; p++) begin
        if (finished[p]) begin
          req[p] = 1'b0;
          finished[p] = 1'b0;
        end
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p] = 1'b1;
          req_addr[p] = $urandom;
          if (p == 1) begin
            d_cmd = $urandom_range(0, 2);
            req_wdata = $urandom;
          end
        end
      end
      if (!act && t >= free_at && (req[0] || req[1])) begin
        if (req[0] && req[1]) act_port = 1 - last_port;
        else act_port = req[1] ? 1 : 0;
        last_port = act_port;
        lat = $urandom_range(0, 6);
        act_ready = (lat <= Timeout);
        le = act_ready ? lat : Timeout;
        act = 1'b1;
        acc_start = t + 1;
        acc_end = t + 1 + le;
        done_t = t + 2 + le;
        free_at = t + 3 + le;
        act_wr = (act_port == 1) && (d_cmd != 0);
        act_addr = req_addr[act_port];
        act_wdata = act_wr ? req_wdata : 32'h0;
        act_rdata = $urandom;
      end
      in_acc = act && t >= acc_start && t <= acc_end;
      if (in_acc) begin
        bus.m_ready = act_ready && (t == acc_end);
        bus.m_rdata = bus.m_ready ? act_rdata : $urandom;
      end else begin
        bus.m_ready = ($urandom_range(0, 3) == 0);
        bus.m_rdata = $urandom;
      end
      bus.i_read  = req[0];
      bus.i_addr  = req_addr[0];
      bus.d_read  = req[1] && (d_cmd != 1);
      bus.d_write = req[1] && (d_cmd != 0);
      bus.d_addr  = req_addr[1];
      bus.d_wdata = req_wdata;
      sample();
      check("rnd_m_read", bus.m_read, in_acc && !act_wr);
      check("rnd_m_write", bus.m_write, in_acc && act_wr);
      if (in_acc) begin
        check("rnd_m_addr", bus.m_addr, act_addr);
        check("rnd_m_wdata", bus.m_wdata, act_wdata);
      end
      if (act && t == done_t) begin
        if (act_port == 0) exp_ir = act_ready ? act_rdata : 32'h0;
        else if (!act_wr) exp_dr = act_ready ? act_rdata : 32'h0;
        if (!act_ready) exp_err = 1'b1;
        finished[act_port] = 1'b1;
        act = 1'b0;
      end
      check("rnd_i_busywait", bus.i_busywait, req[0] && !finished[0]);
      check("rnd_d_busywait", bus.d_busywait, req[1] && !finished[1]);
      check("rnd_i_rdata", bus.i_rdata, exp_ir);
      check("rnd_d_rdata", bus.d_rdata, exp_dr);
      check("rnd_error", bus.error, exp_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
